// File: rtl/pipe_ctrl.sv
// pipe_ctrl: STAGES-deep pipeline register chain carrying {valid, pc, inst,
// rd_en, rd} per stage, with external stall, flush of the younger stages,
// RAW interlock with bubble insertion, and a retired-instruction counter.
//
// Ports
//   clk, rst            clock, synchronous active-low reset
//   f_valid/f_pc/f_inst fetch input; f_ready says it is consumed this cycle
//   d_rs1_en/d_rs1      stage-1 source operand 1 (same for rs2)
//   d_rd_en/d_rd        stage-1 destination, captured on entry to stage 2
//   stall_ext           freezes the whole pipe
//   flush               kills stages 1..FLUSH_UPTO and the incoming fetch
//   vld/pc_bus/inst_bus per-stage state, stage k at index/slice k-1
//   hazard              RAW interlock active this cycle
//   wb_fire             last stage commits this cycle
//   retired             committed-instruction count (wraps)

module pipe_ctrl #(
    parameter int STAGES     = 4,
    parameter int ADDR_W     = 64,
    parameter int INST_W     = 32,
    parameter int REG_AW     = 5,
    parameter int FLUSH_UPTO = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     f_valid,
    input  logic [ADDR_W-1:0]        f_pc,
    input  logic [INST_W-1:0]        f_inst,
    output logic                     f_ready,
    input  logic                     d_rs1_en,
    input  logic                     d_rs2_en,
    input  logic [REG_AW-1:0]        d_rs1,
    input  logic [REG_AW-1:0]        d_rs2,
    input  logic                     d_rd_en,
    input  logic [REG_AW-1:0]        d_rd,
    input  logic                     stall_ext,
    input  logic                     flush,
    output logic [STAGES-1:0]        vld,
    output logic [STAGES*ADDR_W-1:0] pc_bus,
    output logic [STAGES*INST_W-1:0] inst_bus,
    output logic                     hazard,
    output logic                     wb_fire,
    output logic [63:0]              retired
);

    // Index i holds stage i+1. Element 0 of the rd arrays is never loaded
    // with real data: the decode-side rd is only latched on entry to stage 2.
    logic              r_vld   [STAGES];
    logic [ADDR_W-1:0] r_pc    [STAGES];
    logic [INST_W-1:0] r_inst  [STAGES];
    logic              r_rd_en [STAGES];
    logic [REG_AW-1:0] r_rd    [STAGES];
    logic [63:0]       r_retired;

    // Value each stage would take on an advancing edge.
    logic              w_in_vld   [STAGES];
    logic [ADDR_W-1:0] w_in_pc    [STAGES];
    logic [INST_W-1:0] w_in_inst  [STAGES];
    logic              w_in_rd_en [STAGES];
    logic [REG_AW-1:0] w_in_rd    [STAGES];

    logic              w_rs1_hit;
    logic              w_rs2_hit;
    logic              w_hazard;
    logic              w_bubble;
    logic [STAGES-1:0] w_take;

    always_comb begin
        w_in_vld[0]   = f_valid;
        w_in_pc[0]    = f_pc;
        w_in_inst[0]  = f_inst;
        w_in_rd_en[0] = 1'b0;
        w_in_rd[0]    = '0;
        for (int i = 1; i < STAGES; i++) begin
            w_in_vld[i]  = r_vld[i-1];
            w_in_pc[i]   = r_pc[i-1];
            w_in_inst[i] = r_inst[i-1];
            if (i == 1) begin
                w_in_rd_en[i] = d_rd_en;
                w_in_rd[i]    = d_rd;
            end else begin
                w_in_rd_en[i] = r_rd_en[i-1];
                w_in_rd[i]    = r_rd[i-1];
            end
        end
    end

    // No write-to-read bypass in the regfile, so the last stage also blocks.
    always_comb begin
        w_rs1_hit = 1'b0;
        w_rs2_hit = 1'b0;
        for (int j = 1; j < STAGES; j++) begin
            if (r_vld[j] && r_rd_en[j]) begin
                if (d_rs1_en && (d_rs1 != '0) && (r_rd[j] == d_rs1))
                    w_rs1_hit = 1'b1;
                if (d_rs2_en && (d_rs2 != '0) && (r_rd[j] == d_rs2))
                    w_rs2_hit = 1'b1;
            end
        end
    end

    assign w_hazard = rst & r_vld[0] & ~flush & (w_rs1_hit | w_rs2_hit);
    assign w_bubble = ~flush & ~stall_ext & w_hazard;

    // Under flush only the surviving stages may move; under hazard stage 1
    // and fetch hold while stage 2 gets a bubble.
    always_comb begin
        w_take = '0;
        for (int i = 0; i < STAGES; i++) begin
            if (flush)
                w_take[i] = (i >= FLUSH_UPTO) && !stall_ext;
            else
                w_take[i] = !stall_ext && ((i >= 2) || !w_hazard);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < STAGES; i++) begin
                r_vld[i]   <= 1'b0;
                r_pc[i]    <= '0;
                r_inst[i]  <= '0;
                r_rd_en[i] <= 1'b0;
                r_rd[i]    <= '0;
            end
            r_retired <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (flush && (i < FLUSH_UPTO)) begin
                    r_vld[i] <= 1'b0;
                end else if (w_take[i]) begin
                    r_vld[i]   <= w_in_vld[i];
                    r_pc[i]    <= w_in_pc[i];
                    r_inst[i]  <= w_in_inst[i];
                    r_rd_en[i] <= w_in_rd_en[i];
                    r_rd[i]    <= w_in_rd[i];
                end else if ((i == 1) && w_bubble) begin
                    r_vld[i] <= 1'b0;
                end
            end
            if (wb_fire)
                r_retired <= r_retired + 64'd1;
        end
    end

    assign hazard  = w_hazard;
    assign f_ready = rst & ~stall_ext & (flush | ~w_hazard);
    assign wb_fire = rst & r_vld[STAGES-1] & ~stall_ext;
    assign retired = r_retired;

    always_comb begin
        vld      = '0;
        pc_bus   = '0;
        inst_bus = '0;
        for (int i = 0; i < STAGES; i++) begin
            vld[i]                      = r_vld[i];
            pc_bus[i*ADDR_W +: ADDR_W]  = r_pc[i];
            inst_bus[i*INST_W +: INST_W] = r_inst[i];
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         f_valid;
    logic [63:0]  f_pc;
    logic [31:0]  f_inst;
    logic         f_ready;
    logic         d_rs1_en, d_rs2_en, d_rd_en;
    logic [4:0]   d_rs1, d_rs2, d_rd;
    logic         stall_ext, flush;
    logic [3:0]   vld;
    logic [255:0] pc_bus;
    logic [127:0] inst_bus;
    logic         hazard, wb_fire;
    logic [63:0]  retired;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk(clk), .rst(rst),
        .f_valid(f_valid), .f_pc(f_pc), .f_inst(f_inst), .f_ready(f_ready),
        .d_rs1_en(d_rs1_en), .d_rs2_en(d_rs2_en), .d_rs1(d_rs1), .d_rs2(d_rs2),
        .d_rd_en(d_rd_en), .d_rd(d_rd),
        .stall_ext(stall_ext), .flush(flush),
        .vld(vld), .pc_bus(pc_bus), .inst_bus(inst_bus),
        .hazard(hazard), .wb_fire(wb_fire), .retired(retired)
    );

    typedef struct {
        logic        rst, fv;
        logic [63:0] pc;
        logic        r1e;
        logic [4:0]  r1;
        logic        r2e;
        logic [4:0]  r2;
        logic        rde;
        logic [4:0]  rd;
        logic        st, fl;
        logic [3:0]  e_vld;
        logic [63:0] e_pc1, e_pc4;
        logic        e_haz, e_frdy, e_wb;
        logic [63:0] e_ret;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(
        input logic rs, input logic fv, input logic [63:0] pc,
        input logic r1e, input logic [4:0] r1, input logic r2e, input logic [4:0] r2,
        input logic rde, input logic [4:0] rd, input logic st, input logic fl,
        input logic [3:0] ev, input logic [63:0] p1, input logic [63:0] p4,
        input logic eh, input logic ef, input logic ew, input logic [63:0] er);
        vec_t t;
        t.rst = rs; t.fv = fv; t.pc = pc;
        t.r1e = r1e; t.r1 = r1; t.r2e = r2e; t.r2 = r2;
        t.rde = rde; t.rd = rd; t.st = st; t.fl = fl;
        t.e_vld = ev; t.e_pc1 = p1; t.e_pc4 = p4;
        t.e_haz = eh; t.e_frdy = ef; t.e_wb = ew; t.e_ret = er;
        return t;
    endfunction

    function automatic logic [31:0] inst_of(input logic [63:0] pc);
        return {pc[15:0], pc[15:0]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst = 1'b0; f_valid = 1'b0; f_pc = '0; f_inst = '0;
        d_rs1_en = 1'b0; d_rs2_en = 1'b0; d_rs1 = '0; d_rs2 = '0;
        d_rd_en = 1'b0; d_rd = '0; stall_ext = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // reset, fill/drain with independent instructions
        vecs.push_back(v(0,0,'h0,   0,0,0,0,0,0, 0,0, 4'b0000,'h0,  'h0,   0,0,0, 0));
        vecs.push_back(v(1,1,'h0,   0,0,0,0,0,0, 0,0, 4'b0000,'h0,  'h0,   0,1,0, 0));
        vecs.push_back(v(1,1,'h4,   0,0,0,0,1,2, 0,0, 4'b0001,'h0,  'h0,   0,1,0, 0));
        vecs.push_back(v(1,1,'h8,   0,0,0,0,1,3, 0,0, 4'b0011,'h4,  'h0,   0,1,0, 0));
        vecs.push_back(v(1,1,'hC,   0,0,0,0,1,4, 0,0, 4'b0111,'h8,  'h0,   0,1,0, 0));
        vecs.push_back(v(1,0,'h0,   0,0,0,0,1,5, 0,0, 4'b1111,'hC,  'h0,   0,1,1, 0));
        vecs.push_back(v(1,0,'h0,   0,0,0,0,0,0, 0,0, 4'b1110,'h0,  'h4,   0,1,1, 1));
        vecs.push_back(v(1,0,'h0,   0,0,0,0,0,0, 0,0, 4'b1100,'h0,  'h8,   0,1,1, 2));
        vecs.push_back(v(1,0,'h0,   0,0,0,0,0,0, 0,0, 4'b1000,'h0,  'hC,   0,1,1, 3));
        // producer x1, consumer reads x1 right behind
        vecs.push_back(v(1,1,'h100, 0,0,0,0,0,0, 0,0, 4'b0000,'h0,  'h0,   0,1,0, 4));
        vecs.push_back(v(1,1,'h104, 0,0,0,0,1,1, 0,0, 4'b0001,'h100,'h0,   0,1,0, 4));
        vecs.push_back(v(1,1,'h108, 1,1,0,0,1,6, 0,0, 4'b0011,'h104,'h0,   1,0,0, 4));
        vecs.push_back(v(1,1,'h108, 1,1,0,0,1,6, 0,0, 4'b0101,'h104,'h0,   1,0,0, 4));
        vecs.push_back(v(1,1,'h108, 1,1,0,0,1,6, 0,0, 4'b1001,'h104,'h100, 1,0,1, 4));
        vecs.push_back(v(1,1,'h108, 1,1,0,0,1,6, 0,0, 4'b0001,'h104,'h100, 0,1,0, 5));
        // rd=0 producer, consumer reads x0 on both ports
        vecs.push_back(v(1,1,'h200, 0,0,0,0,1,0, 0,0, 4'b0011,'h108,'h100, 0,1,0, 5));
        vecs.push_back(v(1,0,'h0,   1,0,1,0,0,0, 0,0, 4'b0111,'h200,'h100, 0,1,0, 5));
        vecs.push_back(v(1,1,'h300, 0,0,0,0,0,0, 0,0, 4'b1110,'h0,  'h104, 0,1,1, 5));
        vecs.push_back(v(1,1,'h304, 0,0,0,0,0,0, 0,0, 4'b1101,'h300,'h108, 0,1,1, 6));
        vecs.push_back(v(1,1,'h308, 0,0,0,0,0,0, 0,0, 4'b1011,'h304,'h200, 0,1,1, 7));
        vecs.push_back(v(1,1,'h30C, 0,0,0,0,1,7, 0,0, 4'b0111,'h308,'h0,   0,1,0, 8));
        // flush with full pipe; a pending x7 match is masked
        vecs.push_back(v(1,1,'h310, 1,7,0,0,0,0, 0,1, 4'b1111,'h30C,'h300, 0,1,1, 8));
        vecs.push_back(v(1,0,'h0,   0,0,0,0,0,0, 0,0, 4'b1100,'h30C,'h304, 0,1,1, 9));
        vecs.push_back(v(1,1,'h400, 0,0,0,0,0,0, 0,0, 4'b1000,'h0,  'h308, 0,1,1, 10));
        vecs.push_back(v(1,1,'h404, 0,0,0,0,0,0, 0,0, 4'b0001,'h400,'h308, 0,1,0, 11));
        vecs.push_back(v(1,1,'h408, 0,0,0,0,0,0, 0,0, 4'b0011,'h404,'h30C, 0,1,0, 11));
        vecs.push_back(v(1,1,'h40C, 0,0,0,0,0,0, 0,0, 4'b0111,'h408,'h0,   0,1,0, 11));
        // external stall for 5 cycles with a full pipe
        for (int k = 0; k < 5; k++)
            vecs.push_back(v(1,1,'h410, 0,0,0,0,0,0, 1,0, 4'b1111,'h40C,'h400, 0,0,0, 11));
        vecs.push_back(v(1,1,'h410, 0,0,0,0,0,0, 0,0, 4'b1111,'h40C,'h400, 0,1,1, 11));
        vecs.push_back(v(1,0,'h0,   0,0,0,0,0,0, 0,0, 4'b1111,'h410,'h404, 0,1,1, 12));
        // reset mid-stream
        vecs.push_back(v(0,1,'h700, 0,0,0,0,0,0, 0,0, 4'b1110,'h0,  'h408, 0,0,0, 13));
        vecs.push_back(v(0,1,'h700, 0,0,0,0,0,0, 0,0, 4'b0000,'h0,  'h0,   0,0,0, 0));
        vecs.push_back(v(1,1,'h500, 0,0,0,0,0,0, 0,0, 4'b0000,'h0,  'h0,   0,1,0, 0));
        vecs.push_back(v(1,0,'h0,   0,0,0,0,0,0, 0,0, 4'b0001,'h500,'h0,   0,1,0, 0));

        foreach (vecs[n]) begin
            rst = vecs[n].rst; f_valid = vecs[n].fv; f_pc = vecs[n].pc;
            f_inst = inst_of(vecs[n].pc);
            d_rs1_en = vecs[n].r1e; d_rs1 = vecs[n].r1;
            d_rs2_en = vecs[n].r2e; d_rs2 = vecs[n].r2;
            d_rd_en = vecs[n].rde; d_rd = vecs[n].rd;
            stall_ext = vecs[n].st; flush = vecs[n].fl;
            #1;
            chk($sformatf("v%0d vld", n),     vld,             vecs[n].e_vld);
            chk($sformatf("v%0d pc1", n),     pc_bus[63:0],    vecs[n].e_pc1);
            chk($sformatf("v%0d inst1", n),   inst_bus[31:0],  inst_of(vecs[n].e_pc1));
            chk($sformatf("v%0d pc4", n),     pc_bus[255:192], vecs[n].e_pc4);
            chk($sformatf("v%0d hazard", n),  hazard,          vecs[n].e_haz);
            chk($sformatf("v%0d f_ready", n), f_ready,         vecs[n].e_frdy);
            chk($sformatf("v%0d wb_fire", n), wb_fire,         vecs[n].e_wb);
            chk($sformatf("v%0d retired", n), retired,         vecs[n].e_ret);
            @(posedge clk);
            #1;
        end

        // flush together with stall_ext: only killed stages change
        rst = 1'b1; f_valid = 1'b1; f_pc = 'h600; f_inst = inst_of('h600);
        d_rs1_en = 1'b0; d_rs2_en = 1'b0; d_rd_en = 1'b0; stall_ext = 1'b0; flush = 1'b0;
        #1;
        chk("fs pre vld", vld, 4'b0010);
        @(posedge clk); #1;
        chk("fs fill vld", vld, 4'b0101);
        stall_ext = 1'b1; flush = 1'b1; f_pc = 'h604; f_inst = inst_of('h604);
        #1;
        chk("fs f_ready", f_ready, 1'b0);
        chk("fs wb_fire", wb_fire, 1'b0);
        @(posedge clk); #1;
        chk("fs vld", vld, 4'b0100);
        chk("fs pc1", pc_bus[63:0], 'h600);
        chk("fs pc3", pc_bus[191:128], 'h500);
        chk("fs retired", retired, 0);
        stall_ext = 1'b0; flush = 1'b0; f_valid = 1'b0; f_pc = '0; f_inst = '0;
        #1;
        cyc = 0;
        while (!wb_fire && cyc < 6) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("fs wb wait", cyc, 1);
        chk("fs wb pc4", pc_bus[255:192], 'h500);
        @(posedge clk); #1;
        chk("fs retired after", retired, 1);
        chk("fs vld drained", vld, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
